// File: rtl/spell_uart_loader_if.sv
// Wishbone classic master-side bundle between the UART loader and the spell core slave.
// Signal names mirror the core's Wishbone port names so the two sides line up one-to-one.
interface spell_uart_loader_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/spell_uart_loader.sv
// UART (8N1) to Wishbone classic bridge: 'W' addr[4] data[4] writes, 'R' addr[4] reads,
// each command answered over TX with ACK (plus read data) or NAK.
module spell_uart_loader #(
  parameter int CLK_DIV    = 104,
  parameter int WB_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic uart_rx,
  output logic uart_tx,
  output logic o_busy,
  spell_uart_loader_if.master wb
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] WB_LAST   = 16'(WB_TIMEOUT - 1);
  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RESP_ACK  = 8'h06;
  localparam logic [7:0]  RESP_NAK  = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WB, S_RESP} state_e;

  // ---------------- RX ----------------
  logic        rxMeta_q, rxSync_q, rxPrev_q;
  rxState_e    rxState_q;
  logic [15:0] rxCnt_q;
  logic [2:0]  rxBit_q;
  logic [7:0]  rxShift_q;
  logic        rxValid_q, rxErr_q;

  // Both the edge detector and the bit samples use the synchronised line, so the
  // synchroniser latency cancels out and samples land near mid-bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
    end else begin
      rxMeta_q  <= uart_rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            rxState_q <= RX_START;
            rxCnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rxCnt_q == HALF_LAST) begin
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_q <= rxCnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[7:1]};
            rxBit_q   <= rxBit_q + 3'd1;
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
          end else begin
            rxCnt_q <= rxCnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_IDLE;
            rxValid_q <= rxSync_q;
            rxErr_q   <= !rxSync_q;
          end else begin
            rxCnt_q <= rxCnt_q + 16'd1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX ----------------
  logic        txActive_q;
  logic [9:0]  txFrame_q;
  logic [15:0] txCnt_q;
  logic [3:0]  txBit_q;
  logic        txReady, txLoad;
  logic [7:0]  txByte;

  // Ready during the last stop-bit cycle so back-to-back bytes need no idle gap.
  assign txReady = !txActive_q || (txCnt_q == BIT_LAST && txBit_q == 4'd9);
  assign uart_tx = txActive_q ? txFrame_q[0] : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      txActive_q <= 1'b0;
      txFrame_q  <= '1;
      txCnt_q    <= '0;
      txBit_q    <= '0;
    end else if (txLoad && txReady) begin
      txActive_q <= 1'b1;
      txFrame_q  <= {1'b1, txByte, 1'b0};
      txCnt_q    <= '0;
      txBit_q    <= '0;
    end else if (txActive_q) begin
      if (txCnt_q == BIT_LAST) begin
        txCnt_q   <= '0;
        txFrame_q <= {1'b1, txFrame_q[9:1]};
        if (txBit_q == 4'd9) txActive_q <= 1'b0;
        else                 txBit_q    <= txBit_q + 4'd1;
      end else begin
        txCnt_q <= txCnt_q + 16'd1;
      end
    end
  end

  // ---------------- Command parser ----------------
  state_e      state_q, state_d;
  logic [31:0] addr_q, data_q;
  logic [1:0]  byteCnt_q;
  logic        isWrite_q, wbOk_q;
  logic [15:0] wbCnt_q;
  logic [2:0]  respIdx_q;
  logic [2:0]  respLen;
  logic        isCmd, wbCyc, wbWe;

  assign isCmd   = (rxShift_q == CMD_WRITE) || (rxShift_q == CMD_READ);
  assign respLen = (wbOk_q && !isWrite_q) ? 3'd5 : 3'd1;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Framing errors only abort while a frame is being collected; later bytes are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rxValid_q && isCmd) state_d = S_ADDR;
      S_ADDR: begin
        if (rxErr_q)                               state_d = S_IDLE;
        else if (rxValid_q && byteCnt_q == 2'd3)   state_d = isWrite_q ? S_DATA : S_WB;
      end
      S_DATA: begin
        if (rxErr_q)                               state_d = S_IDLE;
        else if (rxValid_q && byteCnt_q == 2'd3)   state_d = S_WB;
      end
      S_WB:   if (wb.i_wb_ack || wbCnt_q == WB_LAST) state_d = S_RESP;
      S_RESP: if (respIdx_q == respLen && txReady)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
    wbCyc  = (state_q == S_WB);
    wbWe   = wbCyc && isWrite_q;
    txLoad = 1'b0;
    txByte = RESP_NAK;
    case (state_q)
      S_IDLE: begin
        if (rxValid_q && !isCmd) txLoad = 1'b1;
      end
      S_RESP: begin
        if (respIdx_q < respLen && txReady) txLoad = 1'b1;
        case (respIdx_q)
          3'd0:    txByte = wbOk_q ? RESP_ACK : RESP_NAK;
          3'd1:    txByte = data_q[31:24];
          3'd2:    txByte = data_q[23:16];
          3'd3:    txByte = data_q[15:8];
          default: txByte = data_q[7:0];
        endcase
      end
      default: ;
    endcase
  end

  // Datapath: big-endian field assembly, ack/timeout bookkeeping, response byte index.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      data_q    <= '0;
      byteCnt_q <= '0;
      isWrite_q <= 1'b0;
      wbOk_q    <= 1'b0;
      wbCnt_q   <= '0;
      respIdx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          byteCnt_q <= '0;
          wbCnt_q   <= '0;
          respIdx_q <= '0;
          if (rxValid_q) isWrite_q <= (rxShift_q == CMD_WRITE);
        end
        S_ADDR: begin
          if (rxValid_q) begin
            addr_q    <= {addr_q[23:0], rxShift_q};
            byteCnt_q <= byteCnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (rxValid_q) begin
            data_q    <= {data_q[23:0], rxShift_q};
            byteCnt_q <= byteCnt_q + 2'd1;
          end
        end
        S_WB: begin
          wbCnt_q <= wbCnt_q + 16'd1;
          if (wb.i_wb_ack) begin
            wbOk_q <= 1'b1;
            if (!isWrite_q) data_q <= wb.i_wb_data;
          end else if (wbCnt_q == WB_LAST) begin
            wbOk_q <= 1'b0;
          end
        end
        S_RESP: begin
          if (txLoad && txReady) respIdx_q <= respIdx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign wb.o_wb_cyc  = wbCyc;
  assign wb.o_wb_stb  = wbCyc;
  assign wb.o_wb_we   = wbWe;
  assign wb.o_wb_sel  = 4'hF;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_data = data_q;

endmodule

// File: tb/tb_spell_uart_loader.sv
// Bench for spell_uart_loader: serial host, Wishbone slave and TX decoder, with expected
// responses built from the command protocol rules.
module tb_spell_uart_loader;

  localparam int CLK_DIV    = 8;
  localparam int WB_TIMEOUT = 16;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, o_busy;

  spell_uart_loader_if wbIf ();

  spell_uart_loader #(.CLK_DIV(CLK_DIV), .WB_TIMEOUT(WB_TIMEOUT)) dut (
    .clock   (clock),
    .reset   (reset),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .o_busy  (o_busy),
    .wb      (wbIf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
    int          len;
    logic        stable;
  } wbRec_t;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          ackDelay    = -1;
  logic [31:0] readVal     = '0;
  int          txFrameErr  = 0;
  wbRec_t      wbQ[$];
  logic [7:0]  txQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Wishbone slave: acks ackDelay cycles after stb (never if negative), logs each cycle.
  initial begin : slaveModel
    int     cnt;
    wbRec_t cur;
    cnt = 0;
    cur.addr = '0; cur.data = '0; cur.we = 1'b0; cur.sel = '0; cur.len = 0; cur.stable = 1'b1;
    wbIf.i_wb_ack  = 1'b0;
    wbIf.i_wb_data = '0;
    forever begin
      @(negedge clock);
      wbIf.i_wb_data = readVal;
      if (wbIf.o_wb_cyc === 1'b1) begin
        if (cnt == 0) begin
          cur.addr   = wbIf.o_wb_addr;
          cur.data   = wbIf.o_wb_data;
          cur.we     = wbIf.o_wb_we;
          cur.sel    = wbIf.o_wb_sel;
          cur.stable = (wbIf.o_wb_stb === 1'b1);
        end else if (wbIf.o_wb_addr !== cur.addr || wbIf.o_wb_data !== cur.data ||
                     wbIf.o_wb_we !== cur.we || wbIf.o_wb_stb !== 1'b1) begin
          cur.stable = 1'b0;
        end
        wbIf.i_wb_ack = (cnt == ackDelay);
        cnt++;
      end else begin
        wbIf.i_wb_ack = 1'b0;
        if (cnt > 0) begin
          cur.len = cnt;
          wbQ.push_back(cur);
          cnt = 0;
        end
      end
    end
  end

  // TX decoder: 8N1, samples near mid-bit, counts bad start/stop bits.
  initial begin : txMonitor
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clock);
      if (uart_tx === 1'b0) begin
        repeat (CLK_DIV / 2 - 1) @(negedge clock);
        if (uart_tx !== 1'b0) txFrameErr++;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clock);
          b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clock);
        if (uart_tx !== 1'b1) txFrameErr++;
        txQ.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b, input bit badStop);
    @(posedge clock);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(posedge clock);
    end
    uart_rx = !badStop;
    repeat (CLK_DIV) @(posedge clock);
    uart_rx = 1'b1;
    if (badStop) repeat (CLK_DIV) @(posedge clock);
  endtask

  // Sends one frame and compares response bytes and Wishbone traffic against the protocol rules.
  task automatic runCommand(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input logic [31:0] rv);
    logic [7:0] frame[$];
    logic [7:0] expResp[$];
    bit         isW, isR, ok, busySeen;
    int         waitCnt, expLen;
    isW = (cmd == 8'h57);
    isR = (cmd == 8'h52);
    ok  = (delay >= 0) && (delay < WB_TIMEOUT);
    expLen = ok ? delay + 1 : WB_TIMEOUT;
    frame.push_back(cmd);
    if (isW || isR) for (int i = 3; i >= 0; i--) frame.push_back(addr[8*i +: 8]);
    if (isW)        for (int i = 3; i >= 0; i--) frame.push_back(data[8*i +: 8]);
    if (!(isW || isR) || !ok) begin
      expResp.push_back(8'h15);
    end else begin
      expResp.push_back(8'h06);
      if (isR) for (int i = 3; i >= 0; i--) expResp.push_back(rv[8*i +: 8]);
    end
    ackDelay = delay;
    readVal  = rv;
    txQ.delete();
    wbQ.delete();
    foreach (frame[i]) applyStimulus(frame[i], 1'b0);
    busySeen = 0;
    waitCnt  = 0;
    while ((txQ.size() < expResp.size() || o_busy) && waitCnt < 4000) begin
      @(negedge clock);
      if (o_busy) busySeen = 1;
      waitCnt++;
    end
    checkOutput("respDone", 32'(waitCnt < 4000), 32'd1);
    repeat (12 * CLK_DIV) @(negedge clock);
    checkOutput("respCount", txQ.size(), expResp.size());
    foreach (expResp[i])
      if (i < txQ.size()) checkOutput($sformatf("respByte%0d", i), 32'(txQ[i]), 32'(expResp[i]));
    checkOutput("txFraming", txFrameErr, 0);
    checkOutput("busyIdle", 32'(o_busy), 32'd0);
    if (isW || isR) begin
      checkOutput("wbCount", wbQ.size(), 1);
      if (wbQ.size() >= 1) begin
        checkOutput("wbAddr", wbQ[0].addr, addr);
        checkOutput("wbWe", 32'(wbQ[0].we), 32'(isW));
        checkOutput("wbSel", 32'(wbQ[0].sel), 32'hF);
        checkOutput("wbCycLen", wbQ[0].len, expLen);
        checkOutput("wbStable", 32'(wbQ[0].stable), 32'd1);
        if (isW) checkOutput("wbData", wbQ[0].data, data);
      end
    end else begin
      checkOutput("wbCountNak", wbQ.size(), 0);
      checkOutput("nakBusy", 32'(busySeen), 32'd0);
    end
  endtask

  initial begin : main
    int         waitCnt;
    int         r;
    logic [7:0] c;

    reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkOutput("rstTx", 32'(uart_tx), 32'd1);
    checkOutput("rstCyc", 32'(wbIf.o_wb_cyc), 32'd0);
    checkOutput("rstStb", 32'(wbIf.o_wb_stb), 32'd0);
    checkOutput("rstWe", 32'(wbIf.o_wb_we), 32'd0);
    checkOutput("rstSel", 32'(wbIf.o_wb_sel), 32'hF);
    checkOutput("rstAddr", wbIf.o_wb_addr, 32'd0);
    checkOutput("rstData", wbIf.o_wb_data, 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    runCommand(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0);
    runCommand(8'h52, 32'h0000_0004, 32'h0, 1, 32'h1234_5678);
    runCommand(8'h41, 32'h0, 32'h0, 0, 32'h0);
    runCommand(8'h57, 32'hCAFE_0000, 32'h0BAD_F00D, -1, 32'h0);
    runCommand(8'h57, 32'h0000_0020, 32'h1122_3344, 0, 32'h0);
    runCommand(8'h52, 32'h8000_0000, 32'h0, WB_TIMEOUT - 1, 32'hA5A5_5A5A);
    runCommand(8'h52, 32'h0000_0008, 32'h0, -1, 32'hFFFF_FFFF);

    // Bad stop bit on the third address byte aborts the frame silently.
    txQ.delete();
    wbQ.delete();
    ackDelay = 1;
    applyStimulus(8'h57, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b1);
    repeat (30 * CLK_DIV) @(negedge clock);
    checkOutput("frameErrResp", txQ.size(), 0);
    checkOutput("frameErrWb", wbQ.size(), 0);
    checkOutput("frameErrBusy", 32'(o_busy), 32'd0);
    runCommand(8'h57, 32'h0000_0030, 32'h5555_AAAA, 3, 32'h0);

    // A two-cycle low pulse is not a start bit.
    txQ.delete();
    wbQ.delete();
    @(posedge clock);
    uart_rx = 1'b0;
    repeat (2) @(posedge clock);
    uart_rx = 1'b1;
    repeat (20 * CLK_DIV) @(negedge clock);
    checkOutput("glitchResp", txQ.size(), 0);
    checkOutput("glitchWb", wbQ.size(), 0);
    checkOutput("glitchBusy", 32'(o_busy), 32'd0);

    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        runCommand(8'h57, $urandom, $urandom, $urandom_range(0, 5), 32'h0);
      end else if (r < 8) begin
        runCommand(8'h52, $urandom, 32'h0, $urandom_range(0, 5), $urandom);
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
        runCommand(c, 32'h0, 32'h0, 0, 32'h0);
      end
    end

    // Reset while the Wishbone cycle is outstanding.
    ackDelay = -1;
    txQ.delete();
    wbQ.delete();
    for (int i = 0; i < 9; i++) applyStimulus((i == 0) ? 8'h57 : 8'(i * 17), 1'b0);
    waitCnt = 0;
    while (wbIf.o_wb_cyc !== 1'b1 && waitCnt < 200) begin
      @(negedge clock);
      waitCnt++;
    end
    checkOutput("rstMidCycSeen", 32'(wbIf.o_wb_cyc), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rstMidCyc", 32'(wbIf.o_wb_cyc), 32'd0);
    checkOutput("rstMidStb", 32'(wbIf.o_wb_stb), 32'd0);
    checkOutput("rstMidTx", 32'(uart_tx), 32'd1);
    checkOutput("rstMidBusy", 32'(o_busy), 32'd0);
    checkOutput("rstMidAddr", wbIf.o_wb_addr, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    txQ.delete();
    wbQ.delete();
    runCommand(8'h57, 32'h0000_0040, 32'h600D_CAFE, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
